multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle LEGv8 control decoder.
- Same 11-bit opcode set (ADDI, ADDS, B, BLT, CBZ, LDUR, LSL, LSR, MUL, STUR, SUBS), sequenced through a Moore FSM.
- Adds a memory ready handshake, a parametrised multi-cycle MUL, resolved branch PC control and a sticky illegal-opcode trap.
- Sits between the instruction register and the shared datapath (ALU, regfile, data memory, PC) of the multi-cycle CPU.

Parameters:
- MUL_CYCLES, 4, total ALU cycles for MUL (>=1); EXEC counts as cycle 1.
- PERF_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  11  instruction bits [31:21] from the instruction register.
- instr_valid  in  1  instruction fetch data valid this cycle.
- mem_ready  in  1  data memory completes the current access this cycle.
- alu_zero  in  1  ALU zero result, for CBZ.
- flag_lt  in  1  stored N^V flag, for BLT.
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg2loc  out  1  second read register select.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- mem_to_reg  out  1  write-back source is memory.
- alu_src  out  1  ALU B operand is immediate.
- alu_op  out  3  ALU operation.
- shift_dir  out  1  0 = left, 1 = right.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky illegal-opcode flag.
- instr_count  out  PERF_W  retired instructions.
- stall_count  out  PERF_W  cycles spent waiting.

Behaviour:
- Reset:
  - state = FETCH; every output = 0; class register, mul counter and perf counters cleared.
  - Synchronous reset mid-instruction abandons it, including a pending memory request.
- Unused control outputs are driven 0 in every state; no x is ever driven.
- Decode encodings (x = don't care):
  - ADDI 1001000100x, ADDS 10101011000, B 000101xxxxx, BLT 01010100xxx, CBZ 10110100xxx.
  - LDUR 11111000010, LSL 11010011011, LSR 11010011010, MUL 10011011000, STUR 11111000000, SUBS 11101011000.
- Opcode class is latched at the end of DECODE; later opcode changes are ignored until the next FETCH.
- FETCH:
  - Waits for instr_valid; stall_count increments while instr_valid = 0.
  - When instr_valid = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE:
  - B: pc_write = 1, pc_src = 1, retire, go to FETCH.
  - Unmatched opcode: go to TRAP.
  - All other opcodes: go to EXEC.
- EXEC, ALU controls per opcode:
  - alu_op: ADDI/ADDS/LDUR/STUR = 010, SUBS = 011, LSL/LSR = 001, MUL = 111, CBZ = 000 (pass B).
  - alu_src = 1 for ADDI/LDUR/STUR/LSL/LSR.
  - reg2loc = 1 for CBZ and STUR.
  - shift_dir = 1 only for LSR.
- EXEC, next state:
  - CBZ: pc_write = 1, pc_src = alu_zero, retire, go to FETCH.
  - BLT: pc_write = 1, pc_src = flag_lt, retire, go to FETCH.
  - MUL with MUL_CYCLES > 1: go to MUL_WAIT.
  - LDUR/STUR: go to MEM.
  - All others: go to WB.
- MUL_WAIT:
  - Holds alu_op = 111 for MUL_CYCLES-1 cycles (down-counter), then go to WB.
  - Counts toward stall_count.
- MEM:
  - LDUR: mem_read = 1; STUR: mem_write = 1, reg2loc = 1.
  - Request held until a cycle with mem_ready = 1.
  - On that cycle: LDUR goes to WB; STUR retires and goes to FETCH.
  - Each cycle with mem_ready = 0 increments stall_count.
- WB:
  - reg_write = 1 for exactly one cycle; mem_to_reg = 1 for LDUR.
  - Retire, go to FETCH.
- TRAP:
  - illegal = 1; all other outputs 0.
  - Stays in TRAP until reset.
- Latency in cycles, with zero-wait inputs:
  - B = 2; CBZ/BLT = 3; ALU ops = 4; STUR = 4; LDUR = 5; MUL = 3 + MUL_CYCLES.

Optional Feature:
- MULTICYCLE_PERF_EN defined:
  - instr_count increments by 1 on each retire.
  - stall_count increments per wait cycle.
  - Both counters wrap modulo 2^PERF_W and clear on reset.
- Not defined: both ports tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then ADDI 10010001000 with instr_valid = 1 -> ir_write in cycle 1, alu_op = 010 and alu_src = 1 in cycle 3, reg_write = 1 only in cycle 4, back in FETCH in cycle 5.
- LDUR 11111000010 with mem_ready low for 2 cycles -> mem_read held 3 cycles, then one WB cycle with mem_to_reg = 1 and reg_write = 1; stall_count = 2 (with MULTICYCLE_PERF_EN).
- MUL 10011011000 with MUL_CYCLES = 4 -> alu_op = 111 for 4 consecutive cycles, reg_write on cycle 7; with MUL_CYCLES = 1, latency = 4.
- CBZ with alu_zero = 1 -> EXEC asserts pc_write = 1, pc_src = 1; with alu_zero = 0 -> pc_write = 1, pc_src = 0; both retire in 3 cycles.
- Opcode 00000000000 -> illegal = 1 from the cycle after DECODE, held for 10 cycles, cleared by reset.
- Reset asserted during MEM of STUR -> mem_write = 0 after the next edge, state FETCH, instr_count = 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle LEGv8 controller (master) and the shared datapath (slave).
interface multicycle_control_if #(
  parameter int PERF_W = 32
);
  logic [10:0]       opcode;
  logic              instr_valid;
  logic              mem_ready;
  logic              alu_zero;
  logic              flag_lt;
  logic              ir_write;
  logic              pc_write;
  logic              pc_src;
  logic              reg2loc;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;
  logic              alu_src;
  logic [2:0]        alu_op;
  logic              shift_dir;
  logic              reg_write;
  logic              illegal;
  logic [PERF_W-1:0] instr_count;
  logic [PERF_W-1:0] stall_count;

  modport master (
    input  opcode, instr_valid, mem_ready, alu_zero, flag_lt,
    output ir_write, pc_write, pc_src, reg2loc, mem_read, mem_write, mem_to_reg,
           alu_src, alu_op, shift_dir, reg_write, illegal, instr_count, stall_count
  );

  modport slave (
    output opcode, instr_valid, mem_ready, alu_zero, flag_lt,
    input  ir_write, pc_write, pc_src, reg2loc, mem_read, mem_write, mem_to_reg,
           alu_src, alu_op, shift_dir, reg_write, illegal, instr_count, stall_count
  );
endinterface

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle control FSM; MULTICYCLE_PERF_EN adds retire/stall counters. Latency B=2, CBZ/BLT=3,
// ALU/STUR=4, LDUR=5, MUL=3+MUL_CYCLES; holds in FETCH while instr_valid low and in MEM while mem_ready low.
module multicycle_control #(
  parameter int MUL_CYCLES = 4,
  parameter int PERF_W     = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MUL_WAIT, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ADDI, C_ADDS, C_B, C_BLT, C_CBZ, C_LDUR,
    C_LSL, C_LSR, C_MUL, C_STUR, C_SUBS
  } cls_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg2loc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       shift_dir;
    logic       reg_write;
    logic       illegal;
  } ctl_t;

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_CYCLES - 1);

  function automatic cls_t decode_op(input logic [10:0] op);
    casez (op)
      11'b1001000100?: decode_op = C_ADDI;
      11'b10101011000: decode_op = C_ADDS;
      11'b000101?????: decode_op = C_B;
      11'b01010100???: decode_op = C_BLT;
      11'b10110100???: decode_op = C_CBZ;
      11'b11111000010: decode_op = C_LDUR;
      11'b11010011011: decode_op = C_LSL;
      11'b11010011010: decode_op = C_LSR;
      11'b10011011000: decode_op = C_MUL;
      11'b11111000000: decode_op = C_STUR;
      11'b11101011000: decode_op = C_SUBS;
      default:         decode_op = C_NONE;
    endcase
  endfunction

  state_t        state, state_nxt;
  cls_t          cls, live_cls;
  logic [CW-1:0] mul_cnt;
  ctl_t          ctl_raw, ctl;

  assign live_cls = decode_op(bus.opcode);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      cls     <= C_NONE;
      mul_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls <= live_cls;
      if (state == S_EXEC && state_nxt == S_MUL_WAIT) mul_cnt <= MUL_INIT;
      else if (state == S_MUL_WAIT) mul_cnt <= mul_cnt - 1'b1;
    end
  end

  always_comb begin
    ctl_raw   = '0;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (bus.instr_valid) begin
          ctl_raw.ir_write = 1'b1;
          ctl_raw.pc_write = 1'b1;
          state_nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        case (live_cls)
          C_B: begin
            ctl_raw.pc_write = 1'b1;
            ctl_raw.pc_src   = 1'b1;
            state_nxt        = S_FETCH;
          end
          C_NONE:  state_nxt = S_TRAP;
          default: state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_ADDI, C_ADDS, C_LDUR, C_STUR: ctl_raw.alu_op = 3'b010;
          C_SUBS:                         ctl_raw.alu_op = 3'b011;
          C_LSL, C_LSR:                   ctl_raw.alu_op = 3'b001;
          C_MUL:                          ctl_raw.alu_op = 3'b111;
          default:                        ctl_raw.alu_op = 3'b000;
        endcase
        ctl_raw.alu_src   = (cls == C_ADDI) || (cls == C_LDUR) || (cls == C_STUR) ||
                            (cls == C_LSL)  || (cls == C_LSR);
        ctl_raw.reg2loc   = (cls == C_CBZ) || (cls == C_STUR);
        ctl_raw.shift_dir = (cls == C_LSR);
        // Branches resolve here so the PC update uses the flags of this cycle.
        case (cls)
          C_CBZ: begin
            ctl_raw.pc_write = 1'b1;
            ctl_raw.pc_src   = bus.alu_zero;
            state_nxt        = S_FETCH;
          end
          C_BLT: begin
            ctl_raw.pc_write = 1'b1;
            ctl_raw.pc_src   = bus.flag_lt;
            state_nxt        = S_FETCH;
          end
          C_MUL:          state_nxt = (MUL_CYCLES > 1) ? S_MUL_WAIT : S_WB;
          C_LDUR, C_STUR: state_nxt = S_MEM;
          default:        state_nxt = S_WB;
        endcase
      end
      S_MUL_WAIT: begin
        ctl_raw.alu_op = 3'b111;
        if (mul_cnt == CW'(1)) state_nxt = S_WB;
      end
      S_MEM: begin
        if (cls == C_STUR) begin
          ctl_raw.mem_write = 1'b1;
          ctl_raw.reg2loc   = 1'b1;
        end else begin
          ctl_raw.mem_read  = 1'b1;
        end
        if (bus.mem_ready) state_nxt = (cls == C_STUR) ? S_FETCH : S_WB;
      end
      S_WB: begin
        ctl_raw.reg_write  = 1'b1;
        ctl_raw.mem_to_reg = (cls == C_LDUR);
        state_nxt          = S_FETCH;
      end
      S_TRAP:  ctl_raw.illegal = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so an abandoned memory request drops immediately.
  always_comb begin
    ctl = ctl_raw;
    if (reset) ctl = '0;
  end

  assign bus.ir_write   = ctl.ir_write;
  assign bus.pc_write   = ctl.pc_write;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.reg2loc    = ctl.reg2loc;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.alu_src    = ctl.alu_src;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.shift_dir  = ctl.shift_dir;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.illegal    = ctl.illegal;

`ifdef MULTICYCLE_PERF_EN
  logic              retire, stall;
  logic [PERF_W-1:0] instr_cnt_q, stall_cnt_q;

  assign retire = (state == S_DECODE && live_cls == C_B) ||
                  (state == S_EXEC && (cls == C_CBZ || cls == C_BLT)) ||
                  (state == S_MEM && bus.mem_ready && cls == C_STUR) ||
                  (state == S_WB);
  assign stall  = (state == S_FETCH && !bus.instr_valid) ||
                  (state == S_MUL_WAIT) ||
                  (state == S_MEM && !bus.mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire) instr_cnt_q <= instr_cnt_q + 1'b1;
      if (stall)  stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.instr_count = instr_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.instr_count = {PERF_W{1'b0}};
  assign bus.stall_count = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised scoreboard bench: per-cycle expected control words are queued by the driver and popped by a monitor.
module tb_multicycle_control;

  localparam int MC = 4;
  localparam int PW = 32;
`ifdef MULTICYCLE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg2loc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       shift_dir;
    logic       reg_write;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t          ctl;
    logic [PW-1:0] ic;
    logic [PW-1:0] sc;
  } exp_t;

  typedef enum int {
    K_ADDI, K_ADDS, K_B, K_BLT, K_CBZ, K_LDUR, K_LSL, K_LSR, K_MUL, K_STUR, K_SUBS, K_BAD
  } kind_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.PERF_W(PW)) bus ();

  multicycle_control #(.MUL_CYCLES(MC), .PERF_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_n  = 0;
  logic [PW-1:0] m_ic, m_sc;

  function automatic logic [10:0] enc(input kind_t k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADDI:  enc = {10'b1001000100, r[0]};
      K_ADDS:  enc = 11'b10101011000;
      K_B:     enc = {6'b000101, r[4:0]};
      K_BLT:   enc = {8'b01010100, r[2:0]};
      K_CBZ:   enc = {8'b10110100, r[2:0]};
      K_LDUR:  enc = 11'b11111000010;
      K_LSL:   enc = 11'b11010011011;
      K_LSR:   enc = 11'b11010011010;
      K_MUL:   enc = 11'b10011011000;
      K_STUR:  enc = 11'b11111000000;
      K_SUBS:  enc = 11'b11101011000;
      default: enc = r[5] ? 11'h000 : 11'h7FF;
    endcase
  endfunction

  // Expected EXEC-cycle control word straight from the opcode table.
  function automatic ctl_t exec_ctl(input kind_t k, input bit br);
    ctl_t c;
    c = '0;
    case (k)
      K_ADDI: begin c.alu_op = 3'b010; c.alu_src = 1'b1; end
      K_ADDS: c.alu_op = 3'b010;
      K_LDUR: begin c.alu_op = 3'b010; c.alu_src = 1'b1; end
      K_STUR: begin c.alu_op = 3'b010; c.alu_src = 1'b1; c.reg2loc = 1'b1; end
      K_SUBS: c.alu_op = 3'b011;
      K_LSL:  begin c.alu_op = 3'b001; c.alu_src = 1'b1; end
      K_LSR:  begin c.alu_op = 3'b001; c.alu_src = 1'b1; c.shift_dir = 1'b1; end
      K_MUL:  c.alu_op = 3'b111;
      K_CBZ:  begin c.reg2loc = 1'b1; c.pc_write = 1'b1; c.pc_src = br; end
      K_BLT:  begin c.pc_write = 1'b1; c.pc_src = br; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic rand_side();
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.mem_ready   = 1'($urandom_range(0, 1));
    bus.alu_zero    = 1'($urandom_range(0, 1));
    bus.flag_lt     = 1'($urandom_range(0, 1));
  endtask

  task automatic cyc(input ctl_t c, input bit ret, input bit stl);
    exp_t e;
    e.ctl = c;
    e.ic  = m_ic;
    e.sc  = m_sc;
    q.push_back(e);
    if (reset) begin
      m_ic = '0;
      m_sc = '0;
    end else if (PERF) begin
      if (ret) m_ic = m_ic + 1'b1;
      if (stl) m_sc = m_sc + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input kind_t k, input int fw, input int mw, input bit br, input bit abort_mem);
    ctl_t        c;
    logic [10:0] op;
    op = enc(k);
    for (int i = 0; i < fw; i++) begin
      rand_side(); bus.instr_valid = 1'b0; bus.opcode = 11'($urandom);
      cyc('0, 1'b0, 1'b1);
    end
    rand_side(); bus.instr_valid = 1'b1; bus.opcode = op;
    c = '0; c.ir_write = 1'b1; c.pc_write = 1'b1;
    cyc(c, 1'b0, 1'b0);
    rand_side(); bus.opcode = op;
    c = '0;
    if (k == K_B) begin
      c.pc_write = 1'b1; c.pc_src = 1'b1;
      cyc(c, 1'b1, 1'b0);
      return;
    end
    cyc(c, 1'b0, 1'b0);
    if (k == K_BAD) begin
      for (int i = 0; i < 10; i++) begin
        rand_side(); bus.opcode = 11'($urandom);
        c = '0; c.illegal = 1'b1;
        cyc(c, 1'b0, 1'b0);
      end
      return;
    end
    // Opcode is scrambled from here on: the latched class must drive everything.
    rand_side(); bus.opcode = 11'($urandom); bus.alu_zero = br; bus.flag_lt = br;
    cyc(exec_ctl(k, br), (k == K_CBZ) || (k == K_BLT), 1'b0);
    if (k == K_CBZ || k == K_BLT) return;
    if (k == K_MUL) begin
      for (int i = 0; i < MC - 1; i++) begin
        rand_side(); bus.opcode = 11'($urandom);
        c = '0; c.alu_op = 3'b111;
        cyc(c, 1'b0, 1'b1);
      end
    end
    if (k == K_LDUR || k == K_STUR) begin
      c = '0;
      if (k == K_STUR) begin c.mem_write = 1'b1; c.reg2loc = 1'b1; end
      else c.mem_read = 1'b1;
      for (int i = 0; i < mw; i++) begin
        rand_side(); bus.opcode = 11'($urandom); bus.mem_ready = 1'b0;
        cyc(c, 1'b0, 1'b1);
      end
      if (abort_mem) begin
        rand_side(); bus.mem_ready = 1'b0; reset = 1'b1;
        cyc('0, 1'b0, 1'b0);
        reset = 1'b0;
        return;
      end
      rand_side(); bus.opcode = 11'($urandom); bus.mem_ready = 1'b1;
      cyc(c, k == K_STUR, 1'b0);
      if (k == K_STUR) return;
    end
    rand_side(); bus.opcode = 11'($urandom);
    c = '0; c.reg_write = 1'b1; c.mem_to_reg = (k == K_LDUR);
    cyc(c, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.ir_write, bus.pc_write, bus.pc_src, bus.reg2loc, bus.mem_read, bus.mem_write,
           bus.mem_to_reg, bus.alu_src, bus.alu_op, bus.shift_dir, bus.reg_write, bus.illegal};
      checks++;
      if (a !== e.ctl) begin
        errors++;
        $display("FAIL ctl cycle %0d: got %b expected %b", cyc_n, a, e.ctl);
      end
      checks++;
      if (bus.instr_count !== e.ic || bus.stall_count !== e.sc) begin
        errors++;
        $display("FAIL counters cycle %0d: got instr=%0d stall=%0d expected instr=%0d stall=%0d",
                 cyc_n, bus.instr_count, bus.stall_count, e.ic, e.sc);
      end
    end
    cyc_n++;
  end

  initial begin
    reset = 1'b1;
    bus.opcode = '0; bus.instr_valid = 1'b0; bus.mem_ready = 1'b0;
    bus.alu_zero = 1'b0; bus.flag_lt = 1'b0;
    m_ic = '0; m_sc = '0;
    @(posedge clk);
    #1;
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_side(); bus.instr_valid = 1'b0;
      cyc('0, 1'b0, 1'b1);
    end

    run_instr(K_ADDI, 0, 0, 1'b0, 1'b0);
    run_instr(K_LDUR, 0, 2, 1'b0, 1'b0);
    run_instr(K_MUL,  0, 0, 1'b0, 1'b0);
    run_instr(K_CBZ,  0, 0, 1'b1, 1'b0);
    run_instr(K_CBZ,  0, 0, 1'b0, 1'b0);
    run_instr(K_BLT,  1, 0, 1'b1, 1'b0);
    run_instr(K_BLT,  0, 0, 1'b0, 1'b0);
    run_instr(K_B,    2, 0, 1'b0, 1'b0);
    run_instr(K_STUR, 0, 1, 1'b0, 1'b0);
    run_instr(K_LSR,  0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      run_instr(kind_t'($urandom_range(0, 10)), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a STUR memory wait abandons the store.
    run_instr(K_STUR, 0, 1, 1'b0, 1'b1);
    rand_side(); bus.instr_valid = 1'b0;
    cyc('0, 1'b0, 1'b1);
    run_instr(K_SUBS, 0, 0, 1'b0, 1'b0);

    // Illegal opcode traps until reset.
    run_instr(K_BAD, 0, 0, 1'b0, 1'b0);
    rand_side(); reset = 1'b1;
    cyc('0, 1'b0, 1'b0);
    reset = 1'b0;
    run_instr(K_ADDS, 1, 0, 1'b0, 1'b0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
